// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and defaults for the mult/div sequencing controller
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } md_state_t;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } md_op_t;

   localparam int DEF_MAX_CYCLES    = 40;
   localparam int DEF_RSTATUS_REG   = 30;
   localparam int DEF_MULT_EXC_CODE = 4;
   localparam int DEF_DIV_EXC_CODE  = 5;

endpackage

// File: rtl/md_watchdog.sv
// rtl/md_watchdog.sv - saturating cycle counter that flags an overlong mult/div operation
module md_watchdog
   import multdiv_pkg::*;
#(
   parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && (count != LIMIT))
         count <= count + 1'b1;
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - issues mult/div operations, stalls the front end and
// produces one registered writeback beat per operation
module multdiv_ctrl
   import multdiv_pkg::*;
#(
   parameter int MAX_CYCLES    = DEF_MAX_CYCLES,
   parameter int RSTATUS_REG   = DEF_RSTATUS_REG,
   parameter int MULT_EXC_CODE = DEF_MULT_EXC_CODE,
   parameter int DIV_EXC_CODE  = DEF_DIV_EXC_CODE
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic        ex_is_mult,
   input  logic        ex_is_div,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_opA,
   input  logic [31:0] ex_opB,
   input  logic        flush,
   output logic        md_ctrl_MULT,
   output logic        md_ctrl_DIV,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_exception
);

   md_state_t   state, state_nxt;
   md_op_t      op_q;
   logic [4:0]  rd_q;
   logic        issue;
   logic        expired;
   logic        busy;

   assign busy  = (state == BUSY);
   assign issue = (state == IDLE) & ex_valid & (ex_is_mult | ex_is_div) & ~flush;

   assign md_operandA = ex_opA;
   assign md_operandB = ex_opB;

   // Counting starts in the issue cycle so the timeout lands MAX_CYCLES after issue.
   md_watchdog #(.MAX_CYCLES(MAX_CYCLES)) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (~busy & ~issue),
      .enable  (issue | busy),
      .expired (expired)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue) state_nxt = BUSY;
         BUSY:    if (flush) state_nxt = IDLE;
                  else if (md_resultRDY || expired) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      md_ctrl_MULT = ~reset & issue & ex_is_mult;
      md_ctrl_DIV  = ~reset & issue & ~ex_is_mult & ex_is_div;
      stall        = ~reset & (issue | busy);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_q <= OP_MULT;
         rd_q <= 5'd0;
      end else if (issue) begin
         op_q <= ex_is_mult ? OP_MULT : OP_DIV;
         rd_q <= ex_rd;
      end
   end

   // Only the BUSY->DONE transition loads the writeback; flush never reaches it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wb_valid     <= 1'b0;
         wb_rd        <= 5'd0;
         wb_data      <= 32'd0;
         wb_exception <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         if (busy && (state_nxt == DONE)) begin
            wb_valid <= 1'b1;
            if (md_resultRDY && !md_exception) begin
               wb_rd        <= rd_q;
               wb_data      <= md_result;
               wb_exception <= 1'b0;
            end else begin
               wb_rd        <= 5'(RSTATUS_REG);
               wb_data      <= (op_q == OP_MULT) ? 32'(MULT_EXC_CODE) : 32'(DIV_EXC_CODE);
               wb_exception <= 1'b1;
            end
         end
      end
   end

endmodule
